// File: rtl/tx_byte_arbiter_if.sv
// Producer-side byte sources and FIFO write-side signals of the TX byte arbiter.
// The slave modport is the arbiter's view; master is the driving environment.
interface tx_byte_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_VLD;
    logic [DATA_WIDTH-1:0]   RD_DATA;
    logic                    RD_VLD;
    logic [DATA_WIDTH-1:0]   STAT_DATA;
    logic                    STAT_VLD;
    logic                    FIFO_FULL;
    logic                    CLR_OVR;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    BUSY;
    logic [2:0]              OVERRUN;

    modport master (
        output ALU_OUT, ALU_VLD, RD_DATA, RD_VLD, STAT_DATA, STAT_VLD, FIFO_FULL, CLR_OVR,
        input  TX_P_DATA, TX_D_VLD, BUSY, OVERRUN
    );

    modport slave (
        input  ALU_OUT, ALU_VLD, RD_DATA, RD_VLD, STAT_DATA, STAT_VLD, FIFO_FULL, CLR_OVR,
        output TX_P_DATA, TX_D_VLD, BUSY, OVERRUN
    );
endinterface

// File: rtl/tx_byte_arbiter.sv
// Round-robin arbiter merging ALU (two bytes, LSB first), register-read and
// status bytes onto the TX FIFO write port, one holding buffer per source.
module tx_byte_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    tx_byte_arbiter_if.slave   bus
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        SEND_ALU_LO,
        SEND_ALU_HI,
        SEND_RD,
        SEND_STAT
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      rr_ptr, rr_nxt;
    logic [2:0]      pend, vld, done, drop, accept, ovr;
    logic [2*DW-1:0] alu_q;
    logic [DW-1:0]   rd_q, stat_q, tx_data;
    logic [1:0]      grant;
    logic            grant_vld;
    logic            in_send, wr;

    assign vld     = {bus.STAT_VLD, bus.RD_VLD, bus.ALU_VLD};
    assign in_send = (state != IDLE);
    // Write strobe is masked during reset so a half-sent ALU word never leaks its high byte.
    assign wr      = in_send & ~bus.FIFO_FULL & RST;

    // First pending source at or after rr_ptr; the loop runs backwards so the nearest wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % 3;
            if (pend[idx]) begin
                grant     = idx[1:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        done      = '0;
        tx_data   = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    case (grant)
                        2'd0:    state_nxt = SEND_ALU_LO;
                        2'd1:    state_nxt = SEND_RD;
                        default: state_nxt = SEND_STAT;
                    endcase
                end
            end
            SEND_ALU_LO: begin
                tx_data = alu_q[DW-1:0];
                if (wr) state_nxt = SEND_ALU_HI;
            end
            SEND_ALU_HI: begin
                tx_data = alu_q[2*DW-1:DW];
                if (wr) begin
                    state_nxt = IDLE;
                    done[0]   = 1'b1;
                    rr_nxt    = 2'd1;
                end
            end
            SEND_RD: begin
                tx_data = rd_q;
                if (wr) begin
                    state_nxt = IDLE;
                    done[1]   = 1'b1;
                    rr_nxt    = 2'd2;
                end
            end
            SEND_STAT: begin
                tx_data = stat_q;
                if (wr) begin
                    state_nxt = IDLE;
                    done[2]   = 1'b1;
                    rr_nxt    = 2'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A buffer freed on this edge may be refilled on the same edge.
    assign drop   = vld & pend & ~done;
    assign accept = vld & ~drop;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            rr_ptr <= '0;
            pend   <= '0;
            ovr    <= '0;
            alu_q  <= '0;
            rd_q   <= '0;
            stat_q <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            pend   <= (pend & ~done) | accept;
            ovr    <= bus.CLR_OVR ? drop : (ovr | drop);
            if (accept[0]) alu_q  <= bus.ALU_OUT;
            if (accept[1]) rd_q   <= bus.RD_DATA;
            if (accept[2]) stat_q <= bus.STAT_DATA;
        end
    end

    assign bus.TX_P_DATA = tx_data;
    assign bus.TX_D_VLD  = wr;
    assign bus.BUSY      = (|pend) | in_send;
    assign bus.OVERRUN   = ovr;
endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Bench for tx_byte_arbiter: vector table, directed corner sequences and a
// randomized run checked every cycle against a queue-based transaction model.
module tb_tx_byte_arbiter;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    tx_byte_arbiter_if #(.DATA_WIDTH(8)) bus ();

    tx_byte_arbiter #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_b),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          rst_b, av, rv, sv, chk;
        logic [15:0] alu;
        logic [7:0]  rd, st;
        bit          ev, eb;
        logic [7:0]  ed;
        logic [2:0]  eo;
    } vec_t;

    // Reference model: per-source pending/data plus the byte queue of the active grant.
    bit          model_on = 1'b0;
    logic [7:0]  mq[$];
    int          msrc = -1;
    bit   [2:0]  mpend = '0;
    int          mrr = 0;
    logic [2:0]  mov = '0;
    logic [15:0] malu = '0;
    logic [7:0]  mrd = '0, mst = '0;
    logic [7:0]  wr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit          ev;
        logic [7:0]  ed;
        ev = rst_b && (mq.size() > 0) && !bus.FIFO_FULL;
        ed = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("model_vld", {31'd0, bus.TX_D_VLD}, {31'd0, ev});
        chk("model_data", {24'd0, bus.TX_P_DATA}, {24'd0, ed});
        chk("model_busy", {31'd0, bus.BUSY}, {31'd0, (mpend != 0) || (msrc >= 0)});
        chk("model_ovr", {29'd0, bus.OVERRUN}, {29'd0, mov});
    endtask

    task automatic model_update();
        bit       wr, was_idle, granted;
        bit [2:0] old_pend, vin, drp;
        int       done;
        if (!rst_b) begin
            mq.delete(); msrc = -1; mpend = '0; mrr = 0; mov = '0;
            malu = '0; mrd = '0; mst = '0;
            return;
        end
        wr       = (mq.size() > 0) && !bus.FIFO_FULL;
        was_idle = (msrc < 0);
        old_pend = mpend;
        done     = -1;
        if (wr) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                done = msrc;
                mpend[msrc] = 1'b0;
                mrr = (msrc + 1) % 3;
                msrc = -1;
            end
        end
        granted = 1'b0;
        if (was_idle) begin
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (mrr + k) % 3;
                if (!granted && old_pend[s]) begin
                    granted = 1'b1;
                    msrc = s;
                    if (s == 0) begin
                        mq.push_back(malu[7:0]);
                        mq.push_back(malu[15:8]);
                    end else begin
                        mq.push_back(s == 1 ? mrd : mst);
                    end
                end
            end
        end
        vin = {bus.STAT_VLD, bus.RD_VLD, bus.ALU_VLD};
        drp = '0;
        for (int i = 0; i < 3; i++) begin
            if (vin[i]) begin
                if (old_pend[i] && done != i) drp[i] = 1'b1;
                else begin
                    mpend[i] = 1'b1;
                    if (i == 0) malu = bus.ALU_OUT;
                    else if (i == 1) mrd = bus.RD_DATA;
                    else mst = bus.STAT_DATA;
                end
            end
        end
        mov = bus.CLR_OVR ? drp : (mov | drp);
    endtask

    // Inputs are set at a negedge; outputs are sampled 1ns later, model advances at posedge.
    task automatic cycle();
        #1;
        if (model_on) model_check();
        if (bus.TX_D_VLD) wr_log.push_back(bus.TX_P_DATA);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.ALU_VLD = 0; bus.RD_VLD = 0; bus.STAT_VLD = 0;
        bus.FIFO_FULL = 0; bus.CLR_OVR = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        quiet();
        rst_b = 1'b0;
        cycle();
        rst_b = 1'b1;
        wr_log.delete();
    endtask

    function automatic vec_t mk(bit r, bit av, logic [15:0] alu, bit rv, logic [7:0] rd,
                                bit sv, logic [7:0] st, bit c, bit ev, logic [7:0] ed, bit eb);
        vec_t v;
        v.rst_b = r; v.av = av; v.alu = alu; v.rv = rv; v.rd = rd; v.sv = sv; v.st = st;
        v.chk = c; v.ev = ev; v.ed = ed; v.eb = eb; v.eo = 3'b000;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        bus.ALU_OUT = '0; bus.RD_DATA = '0; bus.STAT_DATA = '0;
        quiet();

        // single ALU word, then simultaneous three-source request after reset
        tbl[0]  = mk(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        tbl[2]  = mk(1, 1, 16'hA55A, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        tbl[3]  = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[4]  = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h5A, 1);
        tbl[5]  = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 1);
        tbl[6]  = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        tbl[8]  = mk(1, 1, 16'h3344, 1, 8'h11, 1, 8'h22, 1, 0, 8'h00, 0);
        tbl[9]  = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[10] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h44, 1);
        tbl[11] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h33, 1);
        tbl[12] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[13] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 1);
        tbl[14] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[15] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h22, 1);
        tbl[16] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        // rr_ptr back at 0: RD must beat STAT
        tbl[17] = mk(1, 0, 16'h0000, 1, 8'h55, 1, 8'h66, 1, 0, 8'h00, 0);
        tbl[18] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[19] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h55, 1);
        tbl[20] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[21] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 1, 8'h66, 1);
        tbl[22] = mk(1, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            rst_b = tbl[i].rst_b;
            bus.ALU_VLD = tbl[i].av; bus.ALU_OUT = tbl[i].alu;
            bus.RD_VLD = tbl[i].rv;  bus.RD_DATA = tbl[i].rd;
            bus.STAT_VLD = tbl[i].sv; bus.STAT_DATA = tbl[i].st;
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_vld", i), {31'd0, bus.TX_D_VLD}, {31'd0, tbl[i].ev});
                chk($sformatf("tbl%0d_data", i), {24'd0, bus.TX_P_DATA}, {24'd0, tbl[i].ed});
                chk($sformatf("tbl%0d_busy", i), {31'd0, bus.BUSY}, {31'd0, tbl[i].eb});
                chk($sformatf("tbl%0d_ovr", i), {29'd0, bus.OVERRUN}, {29'd0, tbl[i].eo});
            end
            cycle();
            if (i == 0) model_on = 1'b1;
        end
        quiet();

        // FIFO full for 5 cycles while the ALU high byte is offered
        do_reset();
        bus.ALU_VLD = 1; bus.ALU_OUT = 16'hBEEF;
        cycle();
        bus.ALU_VLD = 0;
        run(2);
        bus.FIFO_FULL = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_hold_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
            chk("full_hold_data", {24'd0, bus.TX_P_DATA}, 32'hBE);
            cycle();
        end
        bus.FIFO_FULL = 0;
        #1;
        chk("full_release_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
        run(2);
        chk("full_log_len", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("full_log0", {24'd0, wr_log[0]}, 32'hEF);
            chk("full_log1", {24'd0, wr_log[1]}, 32'hBE);
        end

        // back-to-back RD while pending: second byte dropped, OVERRUN[1] set, then cleared
        do_reset();
        bus.RD_VLD = 1; bus.RD_DATA = 8'h01;
        cycle();
        bus.RD_DATA = 8'h02;
        cycle();
        bus.RD_VLD = 0;
        run(4);
        chk("ovr_log_len", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("ovr_log0", {24'd0, wr_log[0]}, 32'h01);
        #1;
        chk("ovr_flag", {29'd0, bus.OVERRUN}, 32'b010);
        bus.CLR_OVR = 1;
        cycle();
        bus.CLR_OVR = 0;
        #1;
        chk("ovr_cleared", {29'd0, bus.OVERRUN}, 32'd0);

        // RD refill on the edge that writes the pending RD byte
        do_reset();
        bus.RD_VLD = 1; bus.RD_DATA = 8'h66;
        cycle();
        bus.RD_VLD = 0;
        cycle();
        bus.RD_VLD = 1; bus.RD_DATA = 8'h77;
        cycle();
        bus.RD_VLD = 0;
        run(4);
        chk("refill_log_len", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("refill_log0", {24'd0, wr_log[0]}, 32'h66);
            chk("refill_log1", {24'd0, wr_log[1]}, 32'h77);
        end
        #1;
        chk("refill_ovr", {29'd0, bus.OVERRUN}, 32'd0);

        // reset right after the ALU low byte: high byte never written
        do_reset();
        bus.ALU_VLD = 1; bus.ALU_OUT = 16'h1234;
        cycle();
        bus.ALU_OUT = 16'h9999;
        cycle();
        bus.ALU_VLD = 0;
        cycle();
        rst_b = 1'b0;
        cycle();
        rst_b = 1'b1;
        #1;
        chk("rst_mid_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
        chk("rst_mid_data", {24'd0, bus.TX_P_DATA}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_mid_ovr", {29'd0, bus.OVERRUN}, 32'd0);
        run(3);
        chk("rst_mid_log_len", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("rst_mid_log0", {24'd0, wr_log[0]}, 32'h34);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_b = ($urandom_range(0, 299) != 0);
            bus.ALU_VLD = ($urandom_range(0, 3) == 0);
            bus.ALU_OUT = 16'($urandom);
            bus.RD_VLD = ($urandom_range(0, 3) == 0);
            bus.RD_DATA = 8'($urandom);
            bus.STAT_VLD = ($urandom_range(0, 3) == 0);
            bus.STAT_DATA = 8'($urandom);
            bus.FIFO_FULL = ($urandom_range(0, 2) == 0);
            bus.CLR_OVR = ($urandom_range(0, 15) == 0);
            cycle();
        end
        rst_b = 1'b1;
        quiet();
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
